bist_signature_checker: RTL

//  Response-analyser end of the on-chip BIST scan loop. The LFSR pattern generator drives scan_in;

---
 rtl/bist_signature_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bist_signature_checker.sv
// BIST response analyser: compacts NBITS scan_out bits into a CRC signature and checks it against golden.
// Optional stall watchdog enabled by defining BIST_TIMEOUT_EN.
module bist_signature_checker #(
   parameter int               NBITS   = 32,
   parameter int               SIG_W   = 8,
   parameter logic [SIG_W-1:0] POLY    = 8'h1D,
   parameter logic [SIG_W-1:0] SEED    = 8'h00,
   parameter int               TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             scan_en,
   input  logic             scan_out,
   input  logic [SIG_W-1:0] golden,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [SIG_W-1:0] signature
);

   localparam int CW = $clog2(NBITS + 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_DONE} state_t;

   function automatic logic [SIG_W-1:0] compact(input logic [SIG_W-1:0] sig,
                                                input logic             bit_in);
      logic fb;
      fb = sig[SIG_W-1] ^ bit_in;
      return (sig << 1) ^ (fb ? POLY : '0);
   endfunction

   state_t           state_q, state_d;
   logic [SIG_W-1:0] sig_q, sig_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

`ifdef BIST_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT + 1);
   logic [SW-1:0] stall_q, stall_d;
   logic          tmo_q, tmo_d;
`endif

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
`ifdef BIST_TIMEOUT_EN
      stall_d = stall_q;
      tmo_d   = tmo_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               sig_d   = SEED;
               cnt_d   = '0;
               pass_d  = 1'b0;
`ifdef BIST_TIMEOUT_EN
               stall_d = '0;
               tmo_d   = 1'b0;
`endif
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (scan_en) begin
               sig_d = compact(sig_q, scan_out);
               cnt_d = cnt_q + CW'(1);
`ifdef BIST_TIMEOUT_EN
               stall_d = '0;
`endif
               if (cnt_q == CW'(NBITS - 1)) state_d = S_CHECK;
            end
`ifdef BIST_TIMEOUT_EN
            else if (stall_q == SW'(TIMEOUT - 1)) begin
               // Stall limit reached: abort straight to DONE as a failed run.
               stall_d = SW'(TIMEOUT);
               pass_d  = 1'b0;
               tmo_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               stall_d = stall_q + SW'(1);
            end
`endif
         end
         S_CHECK: begin
            pass_d  = (sig_q == golden);
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_COLLECT) || (state_d == S_CHECK);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef BIST_TIMEOUT_EN
         stall_q <= '0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
`ifdef BIST_TIMEOUT_EN
         stall_q <= stall_d;
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig_q;

`ifdef BIST_TIMEOUT_EN
   assign timeout = tmo_q;
`else
   // TIMEOUT only matters with the watchdog; the term folds to constant 0.
   assign timeout = 1'b0 & (TIMEOUT > 0);
`endif

endmodule
